// File: rtl/arbitro_mux_rr_if.sv
// Bus bundle for the two-lane round-robin mux scheduler: lane writes,
// downstream handshake, status flags and grant counters.
interface arbitro_mux_rr_if #(
    parameter int DATA_WIDTH = 2,
    parameter int CNT_WIDTH  = 4
);
    logic                  push0;
    logic [DATA_WIDTH-1:0] data_in0;
    logic                  push1;
    logic [DATA_WIDTH-1:0] data_in1;
    logic                  out_ready;
    logic                  full0;
    logic                  full1;
    logic                  overflow0;
    logic                  overflow1;
    logic                  selector;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic [CNT_WIDTH-1:0]  grant_cnt0;
    logic [CNT_WIDTH-1:0]  grant_cnt1;
    logic                  idle;

    modport master (
        output push0, data_in0, push1, data_in1, out_ready,
        input  full0, full1, overflow0, overflow1, selector, valid_out,
               data_out, grant_cnt0, grant_cnt1, idle
    );

    modport slave (
        input  push0, data_in0, push1, data_in1, out_ready,
        output full0, full1, overflow0, overflow1, selector, valid_out,
               data_out, grant_cnt0, grant_cnt1, idle
    );
endinterface

// File: rtl/arbitro_mux_rr.sv
// Two-lane round-robin scheduler: per-lane FIFOs feed a registered output
// word; the granted lane drives the mux selector.
module arbitro_mux_rr #(
    parameter int DATA_WIDTH = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 4
) (
    input logic             clk,
    input logic             reset,
    arbitro_mux_rr_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr [2];
    logic [PTR_W-1:0]      rd_ptr [2];
    logic [OCC_W-1:0]      count [2];
    logic [DATA_WIDTH-1:0] data_in [2];

    logic [1:0]            push;
    logic [1:0]            full;
    logic [1:0]            nonempty;
    logic [1:0]            push_ok;
    logic [1:0]            pop;
    logic                  grant;
    logic                  gnt_lane;
    logic                  last;
    logic [DATA_WIDTH-1:0] head;

    logic                  selector_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic [CNT_WIDTH-1:0]  grant_cnt0_r;
    logic [CNT_WIDTH-1:0]  grant_cnt1_r;
    logic [1:0]            overflow_r;

    assign push       = {bus.push1, bus.push0};
    assign data_in[0] = bus.data_in0;
    assign data_in[1] = bus.data_in1;

    // Everything below is decided from pre-edge FIFO occupancy, so a word
    // pushed into an empty FIFO cannot be granted on the same edge.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i]     = (count[i] == OCC_W'(FIFO_DEPTH));
            nonempty[i] = (count[i] != '0);
            push_ok[i]  = push[i] && !full[i];
        end
    end

    assign grant    = bus.out_ready && (|nonempty);
    assign gnt_lane = (&nonempty) ? ~last : nonempty[1];
    assign pop      = grant ? (gnt_lane ? 2'b10 : 2'b01) : 2'b00;
    assign head     = mem[gnt_lane][rd_ptr[gnt_lane]];

    // FIFO storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push_ok[i]) begin
                mem[i][wr_ptr[i]] <= data_in[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                count[i] <= count[i] + OCC_W'(push_ok[i]) - OCC_W'(pop[i]);
            end
        end
    end

    // Grant FSM: state records the outcome of the most recent edge; the
    // round-robin pointer survives IDLE so fairness spans stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            selector_r   <= 1'b0;
            data_out_r   <= '0;
            grant_cnt0_r <= '0;
            grant_cnt1_r <= '0;
            last         <= 1'b1;
            overflow_r   <= 2'b00;
        end else begin
            overflow_r <= overflow_r | (push & full);
            if (grant) begin
                state      <= gnt_lane ? SERVE1 : SERVE0;
                selector_r <= gnt_lane;
                last       <= gnt_lane;
                data_out_r <= head;
                if (gnt_lane) begin
                    grant_cnt1_r <= grant_cnt1_r + CNT_WIDTH'(1);
                end else begin
                    grant_cnt0_r <= grant_cnt0_r + CNT_WIDTH'(1);
                end
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.full0      = full[0];
    assign bus.full1      = full[1];
    assign bus.overflow0  = overflow_r[0];
    assign bus.overflow1  = overflow_r[1];
    assign bus.selector   = selector_r;
    assign bus.valid_out  = (state != IDLE);
    assign bus.data_out   = data_out_r;
    assign bus.grant_cnt0 = grant_cnt0_r;
    assign bus.grant_cnt1 = grant_cnt1_r;
    assign bus.idle       = (count[0] == '0) && (count[1] == '0) && (state == IDLE);
endmodule

// File: tb/tb_arbitro_mux_rr.sv
// Directed bench for arbitro_mux_rr: single lane, contention, backpressure,
// overflow, counter wrap and asynchronous reset.
module tb_arbitro_mux_rr;
    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    arbitro_mux_rr_if #(.DATA_WIDTH(2), .CNT_WIDTH(4)) bus ();

    arbitro_mux_rr #(
        .DATA_WIDTH(2),
        .FIFO_DEPTH(4),
        .CNT_WIDTH (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] d, input logic s);
        check({tag, "_valid"}, 32'(bus.valid_out), 32'(v));
        check({tag, "_data"},  32'(bus.data_out),  32'(d));
        check({tag, "_sel"},   32'(bus.selector),  32'(s));
    endtask

    // Assert reset between edges, check it took effect without a clock,
    // hold it across one edge and release.
    task automatic async_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        check({tag, "_valid"}, 32'(bus.valid_out),  32'd0);
        check({tag, "_data"},  32'(bus.data_out),   32'd0);
        check({tag, "_sel"},   32'(bus.selector),   32'd0);
        check({tag, "_cnt0"},  32'(bus.grant_cnt0), 32'd0);
        check({tag, "_cnt1"},  32'(bus.grant_cnt1), 32'd0);
        check({tag, "_ovf1"},  32'(bus.overflow1),  32'd0);
        check({tag, "_full"},  32'({bus.full1, bus.full0}), 32'd0);
        check({tag, "_idle"},  32'(bus.idle),       32'd1);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset = 1'b1;
        bus.push0 = 1'b0;
        bus.data_in0 = 2'b00;
        bus.push1 = 1'b0;
        bus.data_in1 = 2'b00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_out("rst", 1'b0, 2'b00, 1'b0);
        check("rst_idle", 32'(bus.idle), 32'd1);
        reset = 1'b0;

        // Single lane, three words back to back.
        bus.out_ready = 1'b1;
        bus.push0 = 1'b1;
        bus.data_in0 = 2'b01;
        tick();
        check("sl_lat", 32'(bus.valid_out), 32'd0);
        bus.data_in0 = 2'b10;
        tick();
        check_out("sl_w0", 1'b1, 2'b01, 1'b0);
        bus.data_in0 = 2'b11;
        tick();
        check_out("sl_w1", 1'b1, 2'b10, 1'b0);
        bus.push0 = 1'b0;
        tick();
        check_out("sl_w2", 1'b1, 2'b11, 1'b0);
        tick();
        check_out("sl_end", 1'b0, 2'b11, 1'b0);
        check("sl_cnt0", 32'(bus.grant_cnt0), 32'd3);
        check("sl_cnt1", 32'(bus.grant_cnt1), 32'd0);
        check("sl_idle", 32'(bus.idle), 32'd1);

        async_reset("arst");

        // Contention: preload both lanes while stalled.
        bus.out_ready = 1'b0;
        bus.push0 = 1'b1;
        bus.push1 = 1'b1;
        bus.data_in0 = 2'b00;
        bus.data_in1 = 2'b10;
        tick();
        bus.data_in0 = 2'b01;
        bus.data_in1 = 2'b11;
        tick();
        bus.push0 = 1'b0;
        bus.push1 = 1'b0;
        tick();
        check("ct_stall", 32'(bus.valid_out), 32'd0);
        check("ct_busy", 32'(bus.idle), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        check_out("ct_g0", 1'b1, 2'b00, 1'b0);
        tick();
        check_out("ct_g1", 1'b1, 2'b10, 1'b1);
        tick();
        check_out("ct_g2", 1'b1, 2'b01, 1'b0);
        tick();
        check_out("ct_g3", 1'b1, 2'b11, 1'b1);
        check("ct_cnt0", 32'(bus.grant_cnt0), 32'd2);
        check("ct_cnt1", 32'(bus.grant_cnt1), 32'd2);

        // Backpressure: three stalled cycles with both lanes loaded.
        bus.out_ready = 1'b0;
        bus.push0 = 1'b1;
        bus.push1 = 1'b1;
        bus.data_in0 = 2'b01;
        bus.data_in1 = 2'b11;
        tick();
        check_out("bp_c0", 1'b0, 2'b11, 1'b1);
        bus.data_in0 = 2'b10;
        bus.data_in1 = 2'b00;
        tick();
        check_out("bp_c1", 1'b0, 2'b11, 1'b1);
        bus.push0 = 1'b0;
        bus.push1 = 1'b0;
        tick();
        check_out("bp_c2", 1'b0, 2'b11, 1'b1);
        check("bp_cnt0", 32'(bus.grant_cnt0), 32'd2);
        check("bp_cnt1", 32'(bus.grant_cnt1), 32'd2);
        bus.out_ready = 1'b1;
        tick();
        check_out("bp_r0", 1'b1, 2'b01, 1'b0);
        tick();
        check_out("bp_r1", 1'b1, 2'b11, 1'b1);
        tick();
        check_out("bp_r2", 1'b1, 2'b10, 1'b0);
        tick();
        check_out("bp_r3", 1'b1, 2'b00, 1'b1);
        tick();
        check("bp_done", 32'(bus.valid_out), 32'd0);
        check("bp_idle", 32'(bus.idle), 32'd1);
        check("bp_cnt0b", 32'(bus.grant_cnt0), 32'd4);
        check("bp_cnt1b", 32'(bus.grant_cnt1), 32'd4);

        // Overflow: five pushes into a four-deep lane while stalled.
        bus.out_ready = 1'b0;
        bus.push1 = 1'b1;
        bus.data_in1 = 2'b01;
        tick();
        bus.data_in1 = 2'b10;
        tick();
        bus.data_in1 = 2'b11;
        tick();
        check("ov_full3", 32'(bus.full1), 32'd0);
        bus.data_in1 = 2'b00;
        tick();
        check("ov_full4", 32'(bus.full1), 32'd1);
        check("ov_flag4", 32'(bus.overflow1), 32'd0);
        bus.data_in1 = 2'b01;
        tick();
        check("ov_flag5", 32'(bus.overflow1), 32'd1);
        check("ov_flag0", 32'(bus.overflow0), 32'd0);
        bus.push1 = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check_out("ov_d0", 1'b1, 2'b01, 1'b1);
        check("ov_nfull", 32'(bus.full1), 32'd0);
        tick();
        check_out("ov_d1", 1'b1, 2'b10, 1'b1);
        tick();
        check_out("ov_d2", 1'b1, 2'b11, 1'b1);
        tick();
        check_out("ov_d3", 1'b1, 2'b00, 1'b1);
        tick();
        check("ov_only4", 32'(bus.valid_out), 32'd0);
        check("ov_cnt1", 32'(bus.grant_cnt1), 32'd8);
        check("ov_sticky", 32'(bus.overflow1), 32'd1);

        // Counter wrap: seventeen lane-0 grants from a clean start.
        async_reset("wrst");
        bus.out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            bus.push0 = 1'b1;
            bus.data_in0 = k[1:0];
            tick();
            if (k >= 1) begin
                check("wr_data", 32'(bus.data_out), 32'((k - 1) & 3));
                check("wr_valid", 32'(bus.valid_out), 32'd1);
            end
            if (k == 16) begin
                check("wr_cnt16", 32'(bus.grant_cnt0), 32'd0);
            end
        end
        bus.push0 = 1'b0;
        tick();
        check_out("wr_last", 1'b1, 2'b00, 1'b0);
        check("wr_cnt17", 32'(bus.grant_cnt0), 32'd1);

        // Mid-run reset with words queued in both lanes.
        bus.out_ready = 1'b0;
        bus.push0 = 1'b1;
        bus.push1 = 1'b1;
        bus.data_in0 = 2'b10;
        bus.data_in1 = 2'b01;
        tick();
        tick();
        bus.push0 = 1'b0;
        bus.push1 = 1'b0;
        check("mr_busy", 32'(bus.idle), 32'd0);
        async_reset("mrst");
        bus.out_ready = 1'b1;
        tick();
        check("mr_nostale0", 32'(bus.valid_out), 32'd0);
        check("mr_idle", 32'(bus.idle), 32'd1);
        tick();
        check("mr_nostale1", 32'(bus.valid_out), 32'd0);
        check("mr_cnt0", 32'(bus.grant_cnt0), 32'd0);
        check("mr_cnt1", 32'(bus.grant_cnt1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
